// File: rtl/lfsr_prbs_check.sv
// Self-synchronising PRBS checker paired with the lfsr_prbs generator.
// Locks onto the incoming word stream, then free-runs and counts bit errors.
module lfsr_prbs_check #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter                        LFSR_CONFIG  = "FIBONACCI",
    parameter bit                    REVERSE      = 1'b0,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 4,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid,
    input  logic                   count_clear,
    output logic [DATA_WIDTH-1:0]  err_bits,
    output logic                   err_valid,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam int PW = $clog2(DATA_WIDTH + 1);
    localparam int SW = COUNT_WIDTH + PW;

    if (LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
        $error("lfsr_prbs_check: only FIBONACCI configuration is supported");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > LFSR_WIDTH) begin : g_bad_width
        $error("lfsr_prbs_check: DATA_WIDTH must be 1..LFSR_WIDTH");
    end
    if (LOCK_COUNT < 1 || UNLOCK_COUNT < 1) begin : g_bad_counts
        $error("lfsr_prbs_check: LOCK_COUNT and UNLOCK_COUNT must be >= 1");
    end

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t                 state_q, state_d;
    logic [LFSR_WIDTH-1:0]  hist_q, hist_d;
    logic [GW-1:0]          good_q, good_d;
    logic [BW-1:0]          bad_q, bad_d;
    logic [DATA_WIDTH-1:0]  err_bits_q, err_bits_d;
    logic                   err_valid_q, err_valid_d;
    logic                   locked_q, locked_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [LFSR_WIDTH-1:0]  pred_s;
    logic [LFSR_WIDTH-1:0]  feed_s;
    logic [DATA_WIDTH-1:0]  expected;
    logic [DATA_WIDTH-1:0]  mismatch;
    logic [PW-1:0]          pop;
    logic [SW-1:0]          count_sum;
    logic                   fb;
    logic                   d_bit;

    // Unrolled prediction: pred_s free-runs the LFSR, feed_s absorbs the
    // received bits oldest-first so SEARCH can resynchronise.
    always_comb begin
        pred_s   = hist_q;
        feed_s   = hist_q;
        expected = '0;
        fb       = 1'b0;
        d_bit    = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = pred_s[LFSR_WIDTH-1];
            for (int j = 1; j < LFSR_WIDTH; j++) begin
                if (LFSR_POLY[j]) begin
                    fb = fb ^ pred_s[j-1];
                end
            end
            pred_s = {pred_s[LFSR_WIDTH-2:0], fb};
            if (REVERSE) begin
                expected[i] = fb;
                d_bit       = data_in[i];
            end else begin
                expected[DATA_WIDTH-1-i] = fb;
                d_bit                    = data_in[DATA_WIDTH-1-i];
            end
            feed_s = {feed_s[LFSR_WIDTH-2:0], d_bit};
        end
    end

    assign mismatch = data_in ^ expected;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pop = pop + PW'(mismatch[i]);
        end
    end

    assign count_sum = SW'(count_q) + SW'(pop);

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_bits_d  = err_bits_q;
        err_valid_d = 1'b0;
        count_d     = count_q;
        if (data_valid) begin
            unique case (state_q)
                SEARCH: begin
                    hist_d = feed_s;
                    // All-zero data against an empty history must not lock.
                    if (mismatch != '0 ||
                        (data_in == '0 && hist_q == '0)) begin
                        good_d = '0;
                    end else if (good_q == GW'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end
                LOCKED: begin
                    hist_d      = pred_s;
                    err_bits_d  = mismatch;
                    err_valid_d = 1'b1;
                    if (|count_sum[SW-1:COUNT_WIDTH]) begin
                        count_d = '1;
                    end else begin
                        count_d = count_sum[COUNT_WIDTH-1:0];
                    end
                    if (mismatch == '0) begin
                        bad_d = '0;
                    end else if (bad_q == BW'(UNLOCK_COUNT - 1)) begin
                        state_d = SEARCH;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end
            endcase
        end
        if (count_clear) begin
            count_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            hist_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            err_bits_q  <= '0;
            err_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_bits_q  <= err_bits_d;
            err_valid_q <= err_valid_d;
            locked_q    <= locked_d;
            count_q     <= count_d;
        end
    end

    assign err_bits    = err_bits_q;
    assign err_valid   = err_valid_q;
    assign locked      = locked_q;
    assign error_count = count_q;

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Randomised bench for lfsr_prbs_check against a bit-window PRBS31 model.
// Two instances: defaults, and COUNT_WIDTH=4 / UNLOCK_COUNT=8.
module tb_lfsr_prbs_check;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       count_clear;

    logic [7:0]  eb0, eb1;
    logic        ev0, ev1, lk0, lk1;
    logic [31:0] ec0;
    logic [3:0]  ec1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_prbs_check u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .data_valid(data_valid), .count_clear(count_clear),
        .err_bits(eb0), .err_valid(ev0), .locked(lk0),
        .error_count(ec0)
    );

    lfsr_prbs_check #(
        .COUNT_WIDTH(4), .UNLOCK_COUNT(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in),
        .data_valid(data_valid), .count_clear(count_clear),
        .err_bits(eb1), .err_valid(ev1), .locked(lk1),
        .error_count(ec1)
    );

    // Source: PRBS31 bit recurrence b[n] = b[n-31] ^ b[n-28], window[0] oldest.
    bit gh[31];
    // Reference checker state, one set per instance.
    bit         mh[2][31];
    bit         m_lock[2];
    int         m_good[2];
    int         m_bad[2];
    longint     m_cnt[2];
    bit         m_ev[2];
    logic [7:0] m_eb[2];

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gen_word();
        logic [7:0] w;
        bit b;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            b = gh[0] ^ gh[3];
            for (int j = 0; j < 30; j++) gh[j] = gh[j+1];
            gh[30] = b;
            w[7-i] = b;
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 31; j++) mh[k][j] = 1'b0;
            m_lock[k] = 0; m_good[k] = 0; m_bad[k] = 0;
            m_cnt[k] = 0; m_ev[k] = 0; m_eb[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        bit w[31];
        bit b, hz;
        logic [7:0] ex, mis;
        int pop, ulim;
        longint cmax;
        ulim = (k == 0) ? 4 : 8;
        cmax = (k == 0) ? 64'hFFFF_FFFF : 15;
        if (data_valid) begin
            for (int j = 0; j < 31; j++) w[j] = mh[k][j];
            ex = '0;
            for (int i = 0; i < 8; i++) begin
                b = w[0] ^ w[3];
                for (int j = 0; j < 30; j++) w[j] = w[j+1];
                w[30] = b;
                ex[7-i] = b;
            end
            mis = data_in ^ ex;
            pop = $countones(mis);
            hz = 1;
            for (int j = 0; j < 31; j++) if (mh[k][j]) hz = 0;
            if (!m_lock[k]) begin
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < 30; j++) mh[k][j] = mh[k][j+1];
                    mh[k][30] = data_in[7-i];
                end
                m_ev[k] = 0;
                if (mis != 0 || (data_in == 0 && hz)) m_good[k] = 0;
                else begin
                    m_good[k]++;
                    if (m_good[k] == 16) begin
                        m_lock[k] = 1; m_good[k] = 0; m_bad[k] = 0;
                    end
                end
            end else begin
                for (int j = 0; j < 31; j++) mh[k][j] = w[j];
                m_ev[k] = 1;
                m_eb[k] = mis;
                m_cnt[k] = m_cnt[k] + pop;
                if (m_cnt[k] > cmax) m_cnt[k] = cmax;
                if (mis == 0) m_bad[k] = 0;
                else begin
                    m_bad[k]++;
                    if (m_bad[k] == ulim) begin
                        m_lock[k] = 0; m_good[k] = 0; m_bad[k] = 0;
                    end
                end
            end
        end else begin
            m_ev[k] = 0;
        end
        if (count_clear) m_cnt[k] = 0;
    endtask

    task automatic compare_all();
        check("locked0", lk0, m_lock[0]);
        check("err_valid0", ev0, m_ev[0]);
        check("count0", ec0, m_cnt[0]);
        if (m_ev[0]) check("err_bits0", eb0, m_eb[0]);
        check("locked1", lk1, m_lock[1]);
        check("err_valid1", ev1, m_ev[1]);
        check("count1", ec1, m_cnt[1]);
        if (m_ev[1]) check("err_bits1", eb1, m_eb[1]);
    endtask

    task automatic tick(input logic [7:0] d, input logic v, input logic clr);
        data_in = d;
        data_valid = v;
        count_clear = clr;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        logic v;
        logic [7:0] flip;
        for (int j = 0; j < 31; j++) gh[j] = 1'b1;
        rst = 1'b1;
        data_in = '0;
        data_valid = 1'b0;
        count_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        for (int i = 0; i < 10000; i++) tick(gen_word(), 1'b1, 1'b0);
        check("clean_locked", lk0, 1);
        check("clean_count", ec0, 0);

        tick(gen_word() ^ 8'h08, 1'b1, 1'b0);
        check("single_bits", eb0, 8'h08);
        check("single_valid", ev0, 1);
        check("single_count", ec0, 1);
        check("single_locked", lk0, 1);
        for (int i = 0; i < 20; i++) tick(gen_word(), 1'b1, 1'b0);
        check("single_no_mult", ec0, 1);

        tick(gen_word(), 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(gen_word() ^ 8'hFF, 1'b1, 1'b0);
        check("lol_count", ec0, 32);
        check("lol_unlocked", lk0, 0);
        check("lol_sat1", ec1, 15);
        check("lol_still1", lk1, 1);
        n = 0;
        while (!lk0 && n < 40) begin
            tick(gen_word(), 1'b1, 1'b0);
            n++;
        end
        check("relock_words", n, 16);

        tick(gen_word(), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(gen_word() ^ 8'hFF, 1'b1, 1'b0);
        check("sat_count1", ec1, 15);
        check("sat_count0", ec0, 24);
        tick(gen_word() ^ 8'hFF, 1'b1, 1'b1);
        check("clear_prio0", ec0, 0);
        check("clear_prio1", ec1, 0);
        for (int i = 0; i < 24; i++) tick(gen_word(), 1'b1, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            v = 1'(($urandom % 2));
            if (v) begin
                tick(gen_word(), 1'b1, 1'b0);
                n++;
            end else begin
                tick(8'($urandom), 1'b0, 1'b0);
            end
        end
        check("stall_locked", lk0, 1);
        check("stall_count", ec0, 0);

        tick(gen_word() ^ 8'h01, 1'b1, 1'b0);
        check("pre_rst_count", ec0, 1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_locked", lk0, 0);
        check("arst_valid", ev0, 0);
        check("arst_count", ec0, 0);
        check("arst_locked1", lk1, 0);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            v = ($urandom % 4) != 0;
            flip = '0;
            if ($urandom % 12 == 0) flip = 8'(1 << ($urandom % 8));
            if ($urandom % 150 == 0) flip = 8'hFF;
            if (v) tick(gen_word() ^ flip, 1'b1, ($urandom % 200) == 0);
            else tick(8'($urandom), 1'b0, ($urandom % 200) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
